// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering words ahead of the UART transmitter.
// Push when full and pop when empty are ignored; dout shows the oldest entry.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter_cfg.sv
// Configurable UART transmitter: start bit, LSB-first payload, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to buffer words in a 4-entry FIFO instead of a single holding register.
module uart_transmitter_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic                 uart_samplig_clk,
    input  logic                 reset,
    input  logic                 valid,
    output logic                 ready,
    input  logic [DATA_BITS-1:0] data_to_xmit,
    output logic                 RsTx,
    output logic                 busy
);

    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 last_tick;
    logic                 load;
    logic                 word_avail;
    logic [DATA_BITS-1:0] load_data;

    assign last_tick = (tick_q == TICK_LAST);

`ifdef UART_TX_FIFO_EN
    logic                 load_slot;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 bypass;
    logic [DATA_BITS-1:0] fifo_dout;

    // A word offered while the FIFO is empty at a load slot goes straight to the
    // shifter, so an idle line starts the frame on the very next edge.
    assign load_slot  = (state_q == IDLE) ||
                        ((state_q == STOP) && last_tick && (bit_q == STOP_LAST));
    assign ready      = !fifo_full;
    assign bypass     = load_slot && fifo_empty;
    assign fifo_pop   = load_slot && !fifo_empty;
    assign fifo_push  = valid && ready && !bypass;
    assign word_avail = !fifo_empty || (valid && ready);
    assign load_data  = fifo_empty ? data_to_xmit : fifo_dout;
    assign busy       = (state_q != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(4)
    ) u_fifo (
        .clk  (uart_samplig_clk),
        .reset(reset),
        .push (fifo_push),
        .din  (data_to_xmit),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );
`else
    assign ready      = (state_q == IDLE);
    assign word_avail = valid && ready;
    assign load_data  = data_to_xmit;
    assign busy       = (state_q != IDLE);
`endif

    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = ((state_q == IDLE) || last_tick) ? '0 : tick_q + 1'b1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        load     = 1'b0;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (word_avail) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (last_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (last_tick) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (word_avail) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d  = START;
            tick_d   = '0;
            bit_d    = '0;
            shreg_d  = load_data;
            parity_d = (PARITY_MODE == PARITY_ODD) ? ~(^load_data) : ^load_data;
        end

        // The line register is loaded from the next state so it changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign RsTx = tx_q;

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// Self-checking bench for uart_transmitter_cfg: vector table, corner-case sequences and a
// randomized run compared cycle by cycle against a frame-level reference model.
module tb_uart_transmitter_cfg;

    localparam int unsigned OS  = 16;
    localparam int unsigned DB  = 8;
    localparam int unsigned LEN = 160;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, valid = 1'b0, ready, rstx, busy;
    logic [7:0] data = '0;
    logic       reset_o = 1'b1;
    logic       valid_p = 1'b0, ready_p, rstx_p, busy_p;
    logic [6:0] data_p = '0;
    logic       valid_s = 1'b0, ready_s, rstx_s, busy_s;
    logic [4:0] data_s = '0;

    uart_transmitter_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_MODE(0)) dut (
        .uart_samplig_clk(clk), .reset(reset), .valid(valid), .ready(ready),
        .data_to_xmit(data), .RsTx(rstx), .busy(busy));

    uart_transmitter_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_MODE(2)) dut_p (
        .uart_samplig_clk(clk), .reset(reset_o), .valid(valid_p), .ready(ready_p),
        .data_to_xmit(data_p), .RsTx(rstx_p), .busy(busy_p));

    uart_transmitter_cfg #(.DATA_BITS(5), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_MODE(0)) dut_s (
        .uart_samplig_clk(clk), .reset(reset_o), .valid(valid_s), .ready(ready_s),
        .data_to_xmit(data_s), .RsTx(rstx_s), .busy(busy_s));

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level c cycles after a frame for word w started.
    function automatic logic line_bit(input int unsigned w, db, os, pm, c);
        int unsigned k = c / os;
        int unsigned ones = $countones(w & ((32'd1 << db) - 1));
        if (k == 0) return 1'b0;
        if (k <= db) return 1'(w >> (k - 1));
        if (pm != 0 && k == db + 1) return (pm == 1) ? 1'(ones % 2) : 1'((ones + 1) % 2);
        return 1'b1;
    endfunction

    // Reference model for the default instance: queue of accepted words, one frame on the line at a time.
    logic [7:0]  pend[$];
    int unsigned cur_word = 0, cur_c = 0;
    bit          active = 1'b0;
    logic        exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            active = 1'b0;
        end else begin
            if (valid && exp_ready) pend.push_back(data);
            if (active) begin
                if (cur_c + 1 >= LEN) active = 1'b0;
                else cur_c++;
            end
            if (!active && pend.size() != 0) begin
                cur_word = pend.pop_front();
                cur_c = 0;
                active = 1'b1;
            end
        end
        exp_tx    = active ? line_bit(cur_word, DB, OS, 0, cur_c) : 1'b1;
        exp_ready = FIFO ? (pend.size() < 4) : !active;
        exp_busy  = active;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("line", rstx, exp_tx);
            check("ready", ready, exp_ready);
            check("busy", busy, exp_busy);
        end
    end

    task automatic send(input int which, input logic [8:0] w);
        logic got = 1'b0;
        case (which)
            0: begin valid = 1'b1; data = w[7:0]; end
            1: begin valid_p = 1'b1; data_p = w[6:0]; end
            default: begin valid_s = 1'b1; data_s = w[4:0]; end
        endcase
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk);
            case (which)
                0: got = ready;
                1: got = ready_p;
                default: got = ready_s;
            endcase
        end
        check("send_handshake", 32'(got), 1);
        @(posedge clk);
        #1;
        valid = 1'b0; valid_p = 1'b0; valid_s = 1'b0;
    endtask

    task automatic capture(input int which, input int unsigned ncyc,
                           output logic [1023:0] txw, output logic [1023:0] bw);
        txw = '1;
        bw  = '0;
        for (int unsigned c = 0; c < ncyc; c++) begin
            @(negedge clk);
            case (which)
                0: begin txw[c] = rstx; bw[c] = busy; end
                1: begin txw[c] = rstx_p; bw[c] = busy_p; end
                default: begin txw[c] = rstx_s; bw[c] = busy_s; end
            endcase
        end
    endtask

    function automatic int unsigned run_len(input logic [1023:0] v);
        int unsigned n = 0;
        while (n < 1024 && v[n] === 1'b1) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] word;
        logic [9:0] frame;   // line levels at bit centres, start bit in bit 0
    } vec_t;

    vec_t vecs[6];
    logic [7:0] words[5];
    int unsigned acc_cyc[5];

    initial begin
        logic [1023:0] txw, bw;
        logic [9:0]    frame;
        int            glitches, mism, lows, highs, k, nw;
        int unsigned   e, end_c;
        logic          acc, got;

        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'hA1, 10'h342};
        vecs[4] = '{8'h0F, 10'h21E};
        vecs[5] = '{8'h80, 10'h300};
        words   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_tx", rstx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 1);
        check("reset_p", {rstx_p, busy_p, ready_p}, 3'b101);
        check("reset_s", {rstx_s, busy_s, ready_s}, 3'b101);
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_o = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(0, {1'b0, vecs[i].word});
            capture(0, 200, txw, bw);
            frame = '0;
            glitches = 0;
            for (int b = 0; b < 10; b++) begin
                frame[b] = txw[b * 16 + 8];
                for (int j = 0; j < 16; j++) if (txw[b * 16 + j] !== txw[b * 16]) glitches++;
            end
            check($sformatf("vec%0d_frame", i), frame, vecs[i].frame);
            check($sformatf("vec%0d_first_low", i), txw[0], 0);
            check($sformatf("vec%0d_len", i), run_len(bw), LEN);
            check($sformatf("vec%0d_stable", i), glitches, 0);
            check($sformatf("vec%0d_idle_after", i), txw[LEN], 1);
        end

        // Odd parity, 7 data bits, 2 stop bits.
        send(1, 9'h003);
        capture(1, 200, txw, bw);
        mism = 0;
        for (int unsigned c = 0; c < 200; c++) if (txw[c] !== line_bit(32'h03, 7, 16, 2, c)) mism++;
        check("p_wave", mism, 0);
        check("p_parity", txw[8 * 16 + 8], 1);
        check("p_len", run_len(bw), 176);

        // Short frame at OVERSAMPLE=4, DATA_BITS=5.
        send(2, 9'h01F);
        capture(2, 40, txw, bw);
        mism = 0;
        for (int unsigned c = 0; c < 40; c++) if (txw[c] !== line_bit(32'h1F, 5, 4, 0, c)) mism++;
        check("s_wave", mism, 0);
        check("s_len", run_len(bw), 28);
        send(2, 9'h001);
        capture(2, 40, txw, bw);
        check("s_lsb_first", {txw[6], txw[10]}, 2'b10);
        check("s_len2", run_len(bw), 28);

        // Valid held high over several words.
        nw = FIFO ? 5 : 2;
        k = 0;
        valid = 1'b1;
        data = words[0];
        for (int c = 0; c < 2000 && k < nw; c++) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < nw) data = words[k];
                else valid = 1'b0;
            end
        end
        valid = 1'b0;
        check("b2b_accepts", k, nw);
`ifdef UART_TX_FIFO_EN
        check("fifo_accept_span", acc_cyc[4] - acc_cyc[0], 4);
        @(negedge clk);
        check("fifo_full_ready", ready, 0);
`else
        check("hold_gap", acc_cyc[1] - acc_cyc[0], LEN + 1);
`endif
        got = 1'b0;
        end_c = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                end_c = cyc;
            end
        end
        check("b2b_drain", got, 1);
        check("b2b_busy_span", end_c - acc_cyc[0], nw * LEN + (FIFO ? 0 : 1));

        // Reset during data bit 3 of 0x0F, with a second word offered behind it.
        send(0, 9'h00F);
        e = cyc;
        valid = 1'b1;
        data = 8'h33;
        @(posedge clk);
        #1;
        valid = 1'b0;
        while (cyc < e + 70) @(posedge clk);
        @(negedge clk);
        check("rst_bit3_line", rstx, 1);
        check("rst_bit3_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_tx", rstx, 1);
        check("rst_abort_busy", busy, 0);
        check("rst_abort_ready", ready, 1);
        reset = 1'b0;
        capture(0, 400, txw, bw);
        lows = 0;
        highs = 0;
        for (int c = 0; c < 400; c++) begin
            if (txw[c] !== 1'b1) lows++;
            if (bw[c] !== 1'b0) highs++;
        end
        check("rst_residual_line", lows, 0);
        check("rst_residual_busy", highs, 0);

        // Randomized traffic with occasional resets, checked by the model every cycle.
        for (int n = 0; n < 6000; n++) begin
            @(posedge clk);
            #1;
            valid = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
            reset = ($urandom_range(0, 1999) == 0);
        end
        valid = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
